// File: rtl/posit_mac_array.sv
// posit_mac_array: multi-lane posit-weight multiply-accumulate.
// Each accepted beat broadcasts one signed fixed-point activation to LANES lanes.
// Every lane multiplies it by its own posit (es=0) weight and adds the product to a
// saturating fixed-point accumulator. Results are presented once per framed vector.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a new vector (taken only in IDLE); clears accumulators/flags
//   in_valid/in_ready   beat handshake; in_last marks the final beat of the vector
//   act                 signed activation, ACT_WIDTH bits, shared by all lanes
//   w                   lane i posit weight at [i*W_WIDTH +: W_WIDTH]
//   out_valid/out_ready result handshake; results held until taken
//   acc_out             lane i signed sum at [i*ACC_WIDTH +: ACC_WIDTH]
//   nar_out, ovf_out    per-lane sticky NaR-seen / saturated flags
module posit_mac_array #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACT_WIDTH = 8,
  parameter int unsigned W_WIDTH   = 4,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [ACT_WIDTH-1:0]          act,
  input  logic [LANES*W_WIDTH-1:0]      w,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*ACC_WIDTH-1:0]    acc_out,
  output logic [LANES-1:0]              nar_out,
  output logic [LANES-1:0]              ovf_out
);

  // Fraction bits of a decoded weight, mantissa width {1,frac}, product width.
  localparam int unsigned FB  = W_WIDTH - 3;
  localparam int unsigned MW  = FB + 1;
  localparam int unsigned BW  = W_WIDTH - 1;
  localparam int unsigned PW  = ACT_WIDTH + FB + 2;
  // Shift amount ranges 0 .. FRAC_BITS+1.
  localparam int unsigned SHW = $clog2(FRAC_BITS + 2);
  // Shifted term width with headroom for the final negation.
  localparam int unsigned TW  = PW + FRAC_BITS + 2;
  // Full-precision sum width, one bit wider than either operand.
  localparam int unsigned SW  = ((TW > ACC_WIDTH) ? TW : ACC_WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_d;
  logic       clear;
  logic       beat_fire;

  // Pipeline control: s1 holds the decoded beat, then the last-beat marker walks
  // through two more flops so the result is presented exactly three edges after
  // acceptance of in_last.
  logic s1_valid;
  logic s1_last;
  logic last_absorbed;
  logic settled;

  // Stage-1 decode/multiply results (combinational and registered).
  logic [MW-1:0]         dec_mant [LANES];
  logic [SHW-1:0]        dec_sh   [LANES];
  logic signed [PW-1:0]  dec_prod [LANES];
  logic [LANES-1:0]      dec_neg;
  logic [LANES-1:0]      dec_nar;

  logic signed [PW-1:0]  s1_prod  [LANES];
  logic [SHW-1:0]        s1_sh    [LANES];
  logic [LANES-1:0]      s1_neg;
  logic [LANES-1:0]      s1_nar;

  // Stage-2 shift/accumulate intermediates.
  logic [TW-1:0]         term_ext [LANES];
  logic [TW-1:0]         term     [LANES];
  logic [SW-1:0]         sum      [LANES];
  logic [ACC_WIDTH-1:0]  sat_val  [LANES];
  logic [LANES-1:0]      ovf_now;

  assign beat_fire = in_valid & in_ready;

  // Decode one es=0 posit into sign, NaR, mantissa {1,frac} and left shift
  // FRAC_BITS + k - FB. A zero word yields a zero mantissa so its term vanishes.
  function automatic void posit_decode(
    input  logic [W_WIDTH-1:0] word,
    output logic               nar,
    output logic               neg,
    output logic [MW-1:0]      mant,
    output logic [SHW-1:0]     sh
  );
    logic [W_WIDTH-1:0] mag;
    logic [BW-1:0]      body;
    logic [BW-1:0]      scan;
    logic [BW-1:0]      frac_al;
    logic               lead;
    logic               in_run;
    int                 run;
    int                 k;
    int                 sv;
    nar    = (word == {1'b1, {BW{1'b0}}});
    neg    = word[W_WIDTH-1];
    mag    = neg ? (~word + 1'b1) : word;
    body   = mag[BW-1:0];
    lead   = body[BW-1];
    scan   = body;
    in_run = 1'b1;
    run    = 0;
    for (int j = 0; j < int'(BW); j++) begin
      if (in_run && (scan[BW-1] == lead)) run++;
      else in_run = 1'b0;
      scan = scan << 1;
    end
    k = lead ? (run - 1) : -run;
    // Drop regime run and terminator; what remains is the left-aligned fraction.
    frac_al = body << (run + 1);
    mant    = MW'(1 << FB) | MW'(frac_al >> 2);
    if (word == '0) mant = '0;
    sv = int'(FRAC_BITS) + k - int'(FB);
    sh = SHW'(sv);
  endfunction

  // Next-state logic.
  always_comb begin
    state_d = state;
    clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        if (beat_fire && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (settled) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_valid && out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, handshake outputs and pipeline valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      last_absorbed <= 1'b0;
      settled       <= 1'b0;
    end else begin
      state         <= state_d;
      in_ready      <= (state_d == S_RUN);
      out_valid     <= (state_d == S_DONE);
      s1_valid      <= beat_fire;
      s1_last       <= beat_fire & in_last;
      last_absorbed <= s1_valid & s1_last;
      settled       <= last_absorbed;
    end
  end

  // Stage 1: per-lane decode and activation x mantissa product.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      posit_decode(w[i*W_WIDTH +: W_WIDTH], dec_nar[i], dec_neg[i], dec_mant[i], dec_sh[i]);
      dec_prod[i] = $signed({{(PW-ACT_WIDTH){act[ACT_WIDTH-1]}}, act})
                  * $signed({{(PW-MW){1'b0}}, dec_mant[i]});
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) begin
      for (int i = 0; i < int'(LANES); i++) begin
        s1_prod[i] <= dec_prod[i];
        s1_sh[i]   <= dec_sh[i];
      end
      s1_neg <= dec_neg;
      s1_nar <= dec_nar;
    end
  end

  // Stage 2: align term, apply sign, full-width add, then clamp to ACC_WIDTH.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      term_ext[i] = {{(TW-PW){s1_prod[i][PW-1]}}, s1_prod[i]} << s1_sh[i];
      term[i]     = s1_neg[i] ? (~term_ext[i] + 1'b1) : term_ext[i];
      sum[i]      = {{(SW-ACC_WIDTH){acc_out[i*ACC_WIDTH + ACC_WIDTH - 1]}},
                     acc_out[i*ACC_WIDTH +: ACC_WIDTH]}
                  + {{(SW-TW){term[i][TW-1]}}, term[i]};
      // In range iff every bit above the ACC sign bit matches it.
      ovf_now[i]  = !((sum[i][SW-1:ACC_WIDTH-1] == '0) || (sum[i][SW-1:ACC_WIDTH-1] == '1));
      if (ovf_now[i]) begin
        sat_val[i] = sum[i][SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        sat_val[i] = sum[i][ACC_WIDTH-1:0];
      end
    end
  end

  // Accumulators and sticky flags; a lane that has seen NaR is frozen at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_out <= '0;
      nar_out <= '0;
      ovf_out <= '0;
    end else if (s1_valid) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (!nar_out[i]) begin
          if (s1_nar[i]) begin
            nar_out[i]                         <= 1'b1;
            acc_out[i*ACC_WIDTH +: ACC_WIDTH]  <= '0;
          end else begin
            acc_out[i*ACC_WIDTH +: ACC_WIDTH]  <= sat_val[i];
            if (ovf_now[i]) ovf_out[i]         <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_mac_array.sv
// Self-checking bench for posit_mac_array (LANES=2, 8-bit act, posit4 weights,
// 24-bit accumulators with 8 fraction bits). The reference model values posit4
// weights from a table of their real values and accumulates with plain integers.
module tb_posit_mac_array;

  localparam int unsigned LANES     = 2;
  localparam int unsigned ACT_WIDTH = 8;
  localparam int unsigned W_WIDTH   = 4;
  localparam int unsigned ACC_WIDTH = 24;
  localparam int unsigned FRAC_BITS = 8;

  localparam longint ACC_MAX = (longint'(1) << (ACC_WIDTH - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_WIDTH - 1));
  // Table values are weight*4, so one unit is 2^FRAC_BITS/4 in accumulator LSBs.
  localparam longint SCALE   = (longint'(1) << FRAC_BITS) / 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_last;
  logic [ACT_WIDTH-1:0]       act;
  logic [LANES*W_WIDTH-1:0]   w;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*ACC_WIDTH-1:0] acc_out;
  logic [LANES-1:0]           nar_out;
  logic [LANES-1:0]           ovf_out;

  always #5 clk = ~clk;

  posit_mac_array #(
    .LANES(LANES), .ACT_WIDTH(ACT_WIDTH), .W_WIDTH(W_WIDTH),
    .ACC_WIDTH(ACC_WIDTH), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .act(act), .w(w), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .nar_out(nar_out), .ovf_out(ovf_out)
  );

  int checks   = 0;
  int failures = 0;

  // Current vector.
  logic [ACT_WIDTH-1:0]     v_act [$];
  logic [LANES*W_WIDTH-1:0] v_w   [$];

  // Model state.
  longint m_acc [LANES];
  bit     m_nar [LANES];
  bit     m_ovf [LANES];

  // Hand-computed expectations for the current vector.
  bit     lit_en;
  longint lit_acc [LANES];
  bit     lit_nar [LANES];
  bit     lit_ovf [LANES];

  task automatic check_val(input string name, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic signed [63:0] lane_acc(input int l);
    logic [ACC_WIDTH-1:0] v;
    v = acc_out[l*ACC_WIDTH +: ACC_WIDTH];
    return {{(64-ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
  endfunction

  // posit4 (es=0) values times 4.
  function automatic longint posit4_q4(input logic [3:0] p);
    case (p)
      4'b0001: return 1;   4'b0010: return 2;   4'b0011: return 3;
      4'b0100: return 4;   4'b0101: return 6;   4'b0110: return 8;
      4'b0111: return 16;  4'b1001: return -16; 4'b1010: return -8;
      4'b1011: return -6;  4'b1100: return -4;  4'b1101: return -3;
      4'b1110: return -2;  4'b1111: return -1;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    for (int l = 0; l < LANES; l++) begin
      m_acc[l] = 0;
      m_nar[l] = 1'b0;
      m_ovf[l] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [ACT_WIDTH-1:0] a, input logic [LANES*W_WIDTH-1:0] wv);
    for (int l = 0; l < LANES; l++) begin
      logic [3:0] p;
      longint     s;
      p = wv[l*W_WIDTH +: W_WIDTH];
      if (!m_nar[l]) begin
        if (p == 4'b1000) begin
          m_nar[l] = 1'b1;
          m_acc[l] = 0;
        end else begin
          s = m_acc[l] + longint'($signed(a)) * posit4_q4(p) * SCALE;
          if (s > ACC_MAX) begin
            s = ACC_MAX;
            m_ovf[l] = 1'b1;
          end else if (s < ACC_MIN) begin
            s = ACC_MIN;
            m_ovf[l] = 1'b1;
          end
          m_acc[l] = s;
        end
      end
    end
  endtask

  task automatic set_lit(input longint a0, input longint a1, input bit n0, input bit n1,
                         input bit o0, input bit o1);
    lit_en     = 1'b1;
    lit_acc[0] = a0; lit_acc[1] = a1;
    lit_nar[0] = n0; lit_nar[1] = n1;
    lit_ovf[0] = o0; lit_ovf[1] = o1;
  endtask

  // Result checker: whenever results are offered they must equal the model.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      for (int l = 0; l < LANES; l++) begin
        check_val($sformatf("result_acc%0d", l), lane_acc(l), m_acc[l]);
        check_val($sformatf("result_nar%0d", l), nar_out[l], m_nar[l]);
        check_val($sformatf("result_ovf%0d", l), ovf_out[l], m_ovf[l]);
      end
    end
  end

  // Run the queued vector, holding out_ready low for 'hold' cycles in DONE.
  task automatic run_vec(input int hold);
    int n;
    int e;
    n = v_act.size();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    for (int i = 0; i < n; i++) begin
      check_val("in_ready_run", in_ready, 1);
      in_valid = 1'b1;
      act      = v_act[i];
      w        = v_w[i];
      in_last  = (i == n - 1);
      @(posedge clk); #1;
      // Accumulators now reflect beats 0..i-1.
      for (int l = 0; l < LANES; l++) begin
        check_val($sformatf("partial_acc%0d_b%0d", l, i), lane_acc(l), m_acc[l]);
        check_val($sformatf("partial_nar%0d_b%0d", l, i), nar_out[l], m_nar[l]);
        check_val($sformatf("partial_ovf%0d_b%0d", l, i), ovf_out[l], m_ovf[l]);
      end
      model_step(v_act[i], v_w[i]);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_val("in_ready_after_last", in_ready, 0);
    e = 0;
    while (!out_valid && e < 10) begin
      @(posedge clk); #1;
      e++;
    end
    check_val("latency_edges", e, 3);
    if (lit_en) begin
      for (int l = 0; l < LANES; l++) begin
        check_val($sformatf("literal_acc%0d", l), lane_acc(l), lit_acc[l]);
        check_val($sformatf("literal_nar%0d", l), nar_out[l], lit_nar[l]);
        check_val($sformatf("literal_ovf%0d", l), ovf_out[l], lit_ovf[l]);
      end
    end
    for (int h = 0; h < hold; h++) begin
      start = (h == 2);
      @(posedge clk); #1;
      check_val("hold_out_valid", out_valid, 1);
      check_val("hold_in_ready", in_ready, 0);
    end
    // start coincident with the handoff must also be ignored.
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check_val("handoff_out_valid", out_valid, 0);
    check_val("handoff_in_ready", in_ready, 0);
    lit_en = 1'b0;
  endtask

  task automatic load1(input logic [ACT_WIDTH-1:0] a, input logic [LANES*W_WIDTH-1:0] wv);
    v_act.delete();
    v_w.delete();
    v_act.push_back(a);
    v_w.push_back(wv);
  endtask

  longint sweep_exp [7] = '{64, 128, 192, 256, 384, 512, 1024};

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    act = '0; w = '0; out_ready = 1'b0; lit_en = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_in_ready", in_ready, 0);
    check_val("reset_out_valid", out_valid, 0);
    check_val("reset_acc", acc_out, 0);
    check_val("reset_nar", nar_out, 0);
    check_val("reset_ovf", ovf_out, 0);
    rst = 1'b0;

    // Basic: 3*1.5 = 4.5 and 3*-1.
    load1(8'd3, {4'b1100, 4'b0101});
    set_lit(64'h480, -768, 0, 0, 0, 0);
    run_vec(0);

    // All positive posit4 weights, one single-beat vector each.
    for (int p = 1; p <= 7; p++) begin
      logic [3:0] pw;
      pw = 4'(p);
      load1(8'd1, {4'b0000, pw});
      set_lit(sweep_exp[p-1], 0, 0, 0, 0, 0);
      run_vec(0);
    end

    // Saturation: 127*4*256 per beat overflows on the 65th beat.
    v_act.delete();
    v_w.delete();
    for (int i = 0; i < 260; i++) begin
      v_act.push_back(8'd127);
      v_w.push_back({4'b0000, 4'b0111});
    end
    set_lit(64'h7FFFFF, 0, 0, 0, 1, 0);
    run_vec(0);

    // NaR in the middle beat of lane 0.
    v_act.delete();
    v_w.delete();
    v_act.push_back(8'd5); v_w.push_back({4'b0100, 4'b0100});
    v_act.push_back(8'd5); v_w.push_back({4'b0100, 4'b1000});
    v_act.push_back(8'd5); v_w.push_back({4'b0100, 4'b0100});
    set_lit(0, 3840, 1, 0, 0, 0);
    run_vec(0);

    // Backpressure in DONE.
    load1(8'd3, {4'b1100, 4'b0101});
    set_lit(64'h480, -768, 0, 0, 0, 0);
    run_vec(10);

    // Reset after two accepted beats.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    act      = 8'd50;
    w        = {4'b0111, 4'b0111};
    in_last  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_in_ready", in_ready, 0);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_acc", acc_out, 0);
    check_val("midrst_nar", nar_out, 0);
    check_val("midrst_ovf", ovf_out, 0);
    // -2*0.75 and -2*-4.
    load1(8'hFE, {4'b1001, 4'b0011});
    set_lit(-384, 2048, 0, 0, 0, 0);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/posit_mac_array.md
Name: posit_mac_array

Overview:
- Multi-lane posit-weight MAC: one signed fixed-point activation per beat is broadcast to LANES lanes.
- Each lane multiplies it by its own posit (es=0) weight of W_WIDTH bits and accumulates into a saturating fixed-point accumulator over a vector of beats.
- Generalises the single-lane posit4 MAC in weight width, lane count and vector length.
- Adds a framed valid/ready input stream, a held result handshake, and per-lane sticky NaR/overflow flags.
- Sits between the activation buffer and the output requantiser.

Parameters:
LANES, 4, number of independent weight lanes / accumulators
ACT_WIDTH, 8, signed two's-complement activation width
W_WIDTH, 4, posit weight width (es=0), legal 3..8
ACC_WIDTH, 24, signed accumulator width per lane
FRAC_BITS, 8, accumulator fraction bits; must be >= 2*W_WIDTH-5

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin new vector; clears all accumulators and flags
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_last  in  1  marks final beat of vector
act  in  ACT_WIDTH  signed activation
w  in  LANES*W_WIDTH  lane i weight at bits [i*W_WIDTH +: W_WIDTH]
out_valid  out  1  results valid, held until taken
out_ready  in  1  consumer accepts results
acc_out  out  LANES*ACC_WIDTH  lane i signed sum, same packing as w
nar_out  out  LANES  lane saw a NaR weight (sticky per vector)
ovf_out  out  LANES  lane saturated (sticky per vector)

Behaviour:
- Single clock domain: clk. Reset rst is synchronous, active-high.
- Reset (at any time, including mid-vector): state IDLE; in_ready=0; out_valid=0; acc_out=0; nar_out=0; ovf_out=0; pipeline valids cleared; in-flight beats discarded.
- FSM:
  - IDLE: start -> RUN, clear accumulators and flags.
  - RUN: in_ready=1. Accepting a beat with in_last=1 -> DRAIN; in_ready falls the next cycle.
  - DRAIN: waits until stage-2 has absorbed the last beat -> DONE.
  - DONE: out_valid=1, outputs stable. out_valid & out_ready -> IDLE.
- start is ignored outside IDLE, including in the cycle DONE hands off.
- Latency: out_valid rises exactly 3 rising edges after the edge accepting in_last.
- Throughput: 1 beat/cycle. Empty vectors are impossible; the first accepted beat may carry in_last.
- Pipeline:
  - S1 (edge of acceptance): per-lane posit decode plus multiply, registered.
  - S2 (next edge): shift plus saturating accumulate.
- Posit decode, es=0, per lane:
  - 0...0 = zero; term is 0.
  - 10...0 = NaR.
  - Otherwise: s = MSB. If s=1, take the two's complement of the word. Scan bits below the sign.
  - Run of m zeros gives k = -m. Run of m ones gives k = m-1.
  - Skip the terminating bit if present. Remaining bits form the fraction, left-aligned to FB = W_WIDTH-3 bits.
  - M = {1, frac} is unsigned with FB fraction bits.
- Term: T = act * M (signed, ACT_WIDTH+FB+2 bits), shifted left by FRAC_BITS + k - FB (always >= 0), sign-extended, negated if s=1. No rounding is ever required.
- Accumulate: acc + T computed at full width.
  - If the result exceeds the ACC_WIDTH signed range, clamp to max/min and set ovf for that lane.
  - Once saturated, the lane keeps accumulating from the clamped value.
- NaR: on a NaR weight, the lane sets nar, forces acc to 0, and ignores all further terms in that vector. ovf is unchanged.
- Lanes are fully independent. act is shared across all lanes.

Test Plan:
- LANES=2, ACT=8, W=4, ACC=24, FRAC=8: start; one beat act=3, w={1100, 0101}, in_last -> lane0 = 0x000480 (4.5), lane1 = 0xFFFD00 (-3); flags 0; out_valid exactly 3 edges after acceptance.
- Full posit4 sweep: act=1 with w=0001..0111 on separate single-beat vectors -> acc = 64, 128, 192, 256, 384, 512, 1024.
- Saturation: act=127, w=0111 for 260 beats -> acc = 0x7FFFFF; ovf=1 from the first overflowing beat; other lane with w=0000 stays 0, ovf=0.
- NaR: 3-beat vector act=5, lane0 weights 0100, 1000, 0100 -> lane0 acc=0, nar=1; lane1 (w=0100 each beat) = 15*256.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, start ignored; out_ready=1 -> IDLE next cycle.
- Reset mid-RUN after 2 beats -> all outputs 0 next cycle. A following start plus 1-beat vector produces results unaffected by the discarded beats.
